dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
- Sequencer that drives the frequency tuning word (FTW) and enable of the sine DDS core.
- Accepts one sweep command over a valid/ready handshake, then steps the FTW from a start value by a signed increment, holding each tone for a programmable dwell.
- At the end of a sweep it either stops the DDS or holds the last tone.
- Sits between the tile's control interface and the DDS phase accumulator. At the 3 MHz system clock with a 16-bit accumulator, the 200 kHz tone is FTW = 4369.

Parameters:
- FTW_W, 16, width of the tuning word and of the phase accumulator it feeds.
- CNT_W, 8, width of the step count and the step index.
- DWELL_W, 12, width of the dwell cycle count.

Ports:
- clk  in  1  system clock, 3 MHz
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command can be accepted
- cmd_start_ftw  in  FTW_W  first tone FTW
- cmd_step  in  FTW_W  signed two's-complement FTW increment per step
- cmd_nsteps  in  CNT_W  number of steps after the first tone; 0 means a single tone
- cmd_dwell  in  DWELL_W  cycles per tone; 0 is treated as 1
- cmd_hold  in  1  1: hold the last tone after the sweep; 0: stop
- abort  in  1  terminate immediately
- ftw  out  FTW_W  tuning word to the DDS
- dds_en  out  1  DDS accumulate enable
- phase_clr  out  1  one-cycle accumulator clear at each command start
- busy  out  1  sweep in progress
- done  out  1  one-cycle sweep-complete pulse
- step_idx  out  CNT_W  index of the current tone

Behaviour:
- Reset (rst=1 at a clk edge) sets: state IDLE, ftw=0, dds_en=0, phase_clr=0, busy=0, done=0, step_idx=0. rst overrides all inputs. Reset mid-sweep aborts with no done pulse.
- States are IDLE, SWEEP and HOLD. cmd_ready = (state != SWEEP). Accept = cmd_valid & cmd_ready & !abort. All command fields are latched on accept.
- Accept at edge N:
  - From cycle N+1: state SWEEP, ftw=start, dds_en=1, busy=1, step_idx=0.
  - phase_clr=1 during cycle N+1 only.
  - Applies identically from IDLE or HOLD; a command in HOLD restarts the sweep.
- Tone timing: D = max(cmd_dwell, 1). Each tone is presented for exactly D cycles.
  - After D cycles, if step_idx < nsteps: ftw <= ftw + step (modulo 2^FTW_W, silent wrap) and step_idx increments.
  - Total sweep length is (nsteps+1)*D cycles.
- Sweep end, in the cycle after the last tone's final dwell cycle:
  - done=1 for one cycle and busy=0.
  - hold=0: dds_en=0, ftw=0, step_idx=0, state IDLE.
  - hold=1: state HOLD, dds_en=1, ftw and step_idx unchanged.
- abort=1 at an edge, in any state, takes priority over a simultaneous accept:
  - Next cycle: IDLE, dds_en=0, ftw=0, busy=0, step_idx=0, no done pulse.
  - The command is not accepted. abort in IDLE is a no-op.
- Outputs are registered; there is no combinational path from inputs to ftw, dds_en or done. cmd_ready is derived from the state register only.

Decomposition:
- Package dds_ctrl_pkg holds:
  - The state enum (IDLE, SWEEP, HOLD).
  - Default widths.
  - Constant FTW_200K_3M = 16'd4369.
  - A command struct grouping start_ftw, step, nsteps, dwell and hold.
- Sub-module dds_dwell_timer: loadable down-counter with a load input, a value input and a one-cycle expire pulse. It is reused for each tone.

Test Plan:
- Reset: assert rst for 2 cycles mid-sweep -> ftw=0, dds_en=0, busy=0, done=0, cmd_ready=1 next cycle; no done pulse.
- Single tone: start=4369, nsteps=0, dwell=3, hold=0, accepted at edge N -> ftw=4369 and dds_en=1 in cycles N+1..N+3, phase_clr only in N+1; in N+4 done=1, dds_en=0, ftw=0.
- Up sweep: start=1000, step=500, nsteps=3, dwell=2 -> ftw 1000,1000,1500,1500,2000,2000,2500,2500; step_idx 0,0,1,1,2,2,3,3; cmd_ready=0 throughout; then done=1. Repeat with dwell=0 -> each tone lasts 1 cycle.
- Wrap and negative step:
  - start=0xFF00, step=0x0200, nsteps=1, dwell=1 -> 0xFF00 then 0x0100.
  - start=4369, step=0xFFFF, nsteps=2, hold=1 -> 4369, 4368, 4367; done pulse; dds_en stays 1 with ftw=4367 held.
- Restart from HOLD: from the held state, issue start=2000, nsteps=0, dwell=2 -> accepted immediately (cmd_ready=1); phase_clr pulse; ftw=2000 for 2 cycles.
- Abort collision: abort=1 and cmd_valid=1 in the same cycle during SWEEP -> next cycle IDLE, ftw=0, dds_en=0, no done pulse, command not accepted. With cmd_valid held high, the command is accepted on the following cycle.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// Shared types and default widths for the DDS sweep controller.
// The command struct groups one sweep request as offered on the control interface.
package dds_ctrl_pkg;

    localparam int unsigned FTW_W_DEF   = 16;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned DWELL_W_DEF = 12;

    // 200 kHz tone at a 3 MHz clock with a 16-bit accumulator
    localparam logic [FTW_W_DEF-1:0] FTW_200K_3M = 16'd4369;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [FTW_W_DEF-1:0]   start_ftw;
        logic [FTW_W_DEF-1:0]   step;
        logic [CNT_W_DEF-1:0]   nsteps;
        logic [DWELL_W_DEF-1:0] dwell;
        logic                   hold;
    } sweep_cmd_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter timing one tone's dwell; expire_c marks the last cycle of the dwell.
// Reloading on the expire cycle starts the next tone without a gap.
module dds_dwell_timer #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] value,
    output logic         expire_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire_c = (cnt == W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer for the sine DDS: accepts one command, steps the FTW
// from a start value by a signed increment, dwelling D cycles per tone.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned FTW_W   = FTW_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FTW_W-1:0]   cmd_start_ftw,
    input  logic [FTW_W-1:0]   cmd_step,
    input  logic [CNT_W-1:0]   cmd_nsteps,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               cmd_hold,
    input  logic               abort,
    output logic [FTW_W-1:0]   ftw,
    output logic               dds_en,
    output logic               phase_clr,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   step_idx
);

    state_t state, state_d;

    logic [FTW_W-1:0]   ftw_d;
    logic               dds_en_d;
    logic               phase_clr_d;
    logic               busy_d;
    logic               done_d;
    logic [CNT_W-1:0]   step_idx_d;

    logic [FTW_W-1:0]   step_q;
    logic [CNT_W-1:0]   nsteps_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               hold_q;

    logic               accept;
    logic [DWELL_W-1:0] dwell_in_eff;
    logic               tmr_load;
    logic               tmr_clear;
    logic [DWELL_W-1:0] tmr_value;
    logic               tmr_expire;

    assign cmd_ready    = (state != SWEEP);
    assign accept       = cmd_valid & cmd_ready & ~abort;
    assign dwell_in_eff = (cmd_dwell == '0) ? DWELL_W'(1) : cmd_dwell;

    dds_dwell_timer #(
        .W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .clear    (tmr_clear),
        .value    (tmr_value),
        .expire_c (tmr_expire)
    );

    // Command fields needed after the first tone
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= '0;
            nsteps_q <= '0;
            dwell_q  <= DWELL_W'(1);
            hold_q   <= 1'b0;
        end else if (accept) begin
            step_q   <= cmd_step;
            nsteps_q <= cmd_nsteps;
            dwell_q  <= dwell_in_eff;
            hold_q   <= cmd_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ftw       <= '0;
            dds_en    <= 1'b0;
            phase_clr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
        end else begin
            state     <= state_d;
            ftw       <= ftw_d;
            dds_en    <= dds_en_d;
            phase_clr <= phase_clr_d;
            busy      <= busy_d;
            done      <= done_d;
            step_idx  <= step_idx_d;
        end
    end

    // Abort beats accept; accept restarts from IDLE or HOLD alike
    always_comb begin
        state_d     = state;
        ftw_d       = ftw;
        dds_en_d    = dds_en;
        phase_clr_d = 1'b0;
        busy_d      = busy;
        done_d      = 1'b0;
        step_idx_d  = step_idx;
        tmr_load    = 1'b0;
        tmr_clear   = 1'b0;
        tmr_value   = dwell_q;

        if (abort) begin
            state_d    = IDLE;
            ftw_d      = '0;
            dds_en_d   = 1'b0;
            busy_d     = 1'b0;
            step_idx_d = '0;
            tmr_clear  = 1'b1;
        end else if (accept) begin
            state_d     = SWEEP;
            ftw_d       = cmd_start_ftw;
            dds_en_d    = 1'b1;
            phase_clr_d = 1'b1;
            busy_d      = 1'b1;
            step_idx_d  = '0;
            tmr_load    = 1'b1;
            tmr_value   = dwell_in_eff;
        end else begin
            case (state)
                SWEEP: begin
                    if (tmr_expire) begin
                        if (step_idx < nsteps_q) begin
                            ftw_d      = FTW_W'(ftw + step_q);
                            step_idx_d = step_idx + CNT_W'(1);
                            tmr_load   = 1'b1;
                        end else begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                            if (hold_q) begin
                                state_d = HOLD;
                            end else begin
                                state_d    = IDLE;
                                dds_en_d   = 1'b0;
                                ftw_d      = '0;
                                step_idx_d = '0;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares whenever the DUT shows busy, done or phase_clr.
module tb_dds_sweep_ctrl;
    import dds_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_start_ftw;
    logic [15:0] cmd_step;
    logic [7:0]  cmd_nsteps;
    logic [11:0] cmd_dwell;
    logic        cmd_hold;
    logic        abort;
    logic [15:0] ftw;
    logic        dds_en;
    logic        phase_clr;
    logic        busy;
    logic        done;
    logic [7:0]  step_idx;

    typedef struct packed {
        logic [15:0] ftw;
        logic        en;
        logic        pclr;
        logic        busy;
        logic        done;
        logic [7:0]  idx;
        logic        ready;
    } obs_t;

    obs_t        exp_q[$];
    logic [15:0] tv [4];
    int          checks = 0;
    int          errors = 0;
    string       cur_name = "init";

    dds_sweep_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_start_ftw (cmd_start_ftw),
        .cmd_step      (cmd_step),
        .cmd_nsteps    (cmd_nsteps),
        .cmd_dwell     (cmd_dwell),
        .cmd_hold      (cmd_hold),
        .abort         (abort),
        .ftw           (ftw),
        .dds_en        (dds_en),
        .phase_clr     (phase_clr),
        .busy          (busy),
        .done          (done),
        .step_idx      (step_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t get_obs();
        obs_t o;
        o.ftw   = ftw;
        o.en    = dds_en;
        o.pclr  = phase_clr;
        o.busy  = busy;
        o.done  = done;
        o.idx   = step_idx;
        o.ready = cmd_ready;
        return o;
    endfunction

    function automatic sweep_cmd_t mk(input logic [15:0] s, input logic [15:0] st,
                                      input logic [7:0] n, input logic [11:0] d, input logic h);
        sweep_cmd_t c;
        c.start_ftw = s;
        c.step      = st;
        c.nsteps    = n;
        c.dwell     = d;
        c.hold      = h;
        return c;
    endfunction

    // Expand the hand-written tone list tv[] by the effective dwell; limit<0 means whole sweep
    function automatic void push_exp(input sweep_cmd_t c, input int d_eff, input int ntones, input int limit);
        int   n = 0;
        obs_t e;
        for (int k = 0; k < ntones; k++) begin
            for (int d = 0; d < d_eff; d++) begin
                if (limit >= 0 && n >= limit) return;
                e.ftw   = tv[k];
                e.en    = 1'b1;
                e.pclr  = (k == 0 && d == 0);
                e.busy  = 1'b1;
                e.done  = 1'b0;
                e.idx   = 8'(k);
                e.ready = 1'b0;
                exp_q.push_back(e);
                n++;
            end
        end
        if (limit >= 0 && n >= limit) return;
        e.pclr  = 1'b0;
        e.busy  = 1'b0;
        e.done  = 1'b1;
        e.ready = 1'b1;
        if (c.hold) begin
            e.ftw = tv[ntones-1];
            e.en  = 1'b1;
            e.idx = 8'(ntones-1);
        end else begin
            e.ftw = 16'd0;
            e.en  = 1'b0;
            e.idx = 8'd0;
        end
        exp_q.push_back(e);
    endfunction

    // Monitor: every cycle the DUT presents activity must match the next queued expectation
    always @(negedge clk) begin
        obs_t o;
        obs_t e;
        if (busy || done || phase_clr) begin
            o = get_obs();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s unexpected_cycle: got ftw=%0d en=%b pclr=%b busy=%b done=%b idx=%0d ready=%b, expected no activity",
                         cur_name, o.ftw, o.en, o.pclr, o.busy, o.done, o.idx, o.ready);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s sweep_cycle: got ftw=%0d en=%b pclr=%b busy=%b done=%b idx=%0d ready=%b, expected ftw=%0d en=%b pclr=%b busy=%b done=%b idx=%0d ready=%b",
                             cur_name, o.ftw, o.en, o.pclr, o.busy, o.done, o.idx, o.ready,
                             e.ftw, e.en, e.pclr, e.busy, e.done, e.idx, e.ready);
                end
            end
        end
    end

    task automatic chk_state(input string nm, input obs_t e);
        obs_t o;
        o = get_obs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s %s: got ftw=%0d en=%b pclr=%b busy=%b done=%b idx=%0d ready=%b, expected ftw=%0d en=%b pclr=%b busy=%b done=%b idx=%0d ready=%b",
                     cur_name, nm, o.ftw, o.en, o.pclr, o.busy, o.done, o.idx, o.ready,
                     e.ftw, e.en, e.pclr, e.busy, e.done, e.idx, e.ready);
        end
    endtask

    task automatic drive(input sweep_cmd_t c);
        cmd_start_ftw = c.start_ftw;
        cmd_step      = c.step;
        cmd_nsteps    = c.nsteps;
        cmd_dwell     = c.dwell;
        cmd_hold      = c.hold;
    endtask

    task automatic chk_ready();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready: got %b, expected 1", cur_name, cmd_ready);
        end
    endtask

    // Offer a command for one cycle; it must be accepted at the coming edge
    task automatic send(input sweep_cmd_t c, input int d_eff, input int ntones, input int limit);
        @(negedge clk);
        drive(c);
        cmd_valid = 1'b1;
        #1;
        chk_ready();
        push_exp(c, d_eff, ntones, limit);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain_timeout: got %0d pending expectations, expected 0", cur_name, exp_q.size());
            exp_q.delete();
        end
    endtask

    localparam obs_t IDLE_OBS = '{ftw: 16'd0, en: 1'b0, pclr: 1'b0, busy: 1'b0,
                                  done: 1'b0, idx: 8'd0, ready: 1'b1};

    initial begin
        obs_t held;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        drive(mk(16'd0, 16'd0, 8'd0, 12'd0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        #1;
        cur_name = "reset";
        chk_state("reset_values", IDLE_OBS);
        rst = 1'b0;

        cur_name = "single_tone";
        tv = '{FTW_200K_3M, 16'd0, 16'd0, 16'd0};
        send(mk(16'd4369, 16'd0, 8'd0, 12'd3, 1'b0), 3, 1, -1);
        wait_drain(50);
        @(negedge clk);
        #1;
        chk_state("idle_after", IDLE_OBS);

        cur_name = "up_sweep";
        tv = '{16'd1000, 16'd1500, 16'd2000, 16'd2500};
        send(mk(16'd1000, 16'd500, 8'd3, 12'd2, 1'b0), 2, 4, -1);
        wait_drain(50);

        cur_name = "up_sweep_dwell0";
        send(mk(16'd1000, 16'd500, 8'd3, 12'd0, 1'b0), 1, 4, -1);
        wait_drain(50);

        cur_name = "wrap";
        tv = '{16'hFF00, 16'h0100, 16'd0, 16'd0};
        send(mk(16'hFF00, 16'h0200, 8'd1, 12'd1, 1'b0), 1, 2, -1);
        wait_drain(50);

        cur_name = "neg_step_hold";
        tv = '{16'd4369, 16'd4368, 16'd4367, 16'd0};
        send(mk(16'd4369, 16'hFFFF, 8'd2, 12'd2, 1'b1), 2, 3, -1);
        wait_drain(50);
        held = '{ftw: 16'd4367, en: 1'b1, pclr: 1'b0, busy: 1'b0, done: 1'b0, idx: 8'd2, ready: 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_state("held_tone", held);
        end

        cur_name = "restart_from_hold";
        tv = '{16'd2000, 16'd0, 16'd0, 16'd0};
        send(mk(16'd2000, 16'd0, 8'd0, 12'd2, 1'b0), 2, 1, -1);
        wait_drain(50);

        // Abort during SWEEP with a colliding command held valid
        cur_name = "abort_collision";
        tv = '{16'd100, 16'd0, 16'd0, 16'd0};
        @(negedge clk);
        drive(mk(16'd100, 16'd1, 8'd10, 12'd4, 1'b0));
        cmd_valid = 1'b1;
        #1;
        chk_ready();
        push_exp(mk(16'd100, 16'd1, 8'd10, 12'd4, 1'b0), 4, 1, 3);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        cmd_valid = 1'b1;
        drive(mk(16'd3000, 16'd0, 8'd0, 12'd1, 1'b0));
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk_state("idle_after_abort", IDLE_OBS);
        tv = '{16'd3000, 16'd0, 16'd0, 16'd0};
        push_exp(mk(16'd3000, 16'd0, 8'd0, 12'd1, 1'b0), 1, 1, -1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_drain(50);

        cur_name = "abort_in_idle";
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk_state("idle_noop", IDLE_OBS);

        // Reset mid-sweep: no done pulse may follow
        cur_name = "reset_mid_sweep";
        tv = '{16'd1000, 16'd1500, 16'd2000, 16'd2500};
        send(mk(16'd1000, 16'd500, 8'd3, 12'd2, 1'b0), 2, 4, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_state("idle_after_reset", IDLE_OBS);
        for (int i = 0; i < 4; i++) @(negedge clk);
        wait_drain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
